imem_loader: RTL and testbench

Boot-time program loader that owns the write port of the CPU's instruction memory. It accepts a length-prefixed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses from 0. The CPU is held in reset and disabled until the load completes, then released. It sits between the host/bench byte source and the CPU's `reset`/`enable` inputs.

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Purpose: boot loader that streams a length-prefixed byte frame into instruction memory, holding the CPU in reset until done.
// Latency: mem_we rises the cycle after the 4th byte of a word is accepted; DONE (cpu_enable) follows the last write by one cycle.
// Backpressure: in_ready is combinational from state; it drops during WRITE/DONE/ERROR and while reset is low.
//
// Ports:
//   clock, reset (sync, active-low)      - clocking / reset
//   in_valid, in_data, in_ready          - byte stream handshake: LEN_HI, LEN_LO, then 4*N bytes
//   reload                               - restart a load; only acted on in DONE or ERROR
//   mem_we, mem_addr, mem_wdata          - instruction-memory write port (addr/data hold when mem_we=0)
//   cpu_reset, cpu_enable                - CPU control; CPU released only in DONE
//   busy, done, error, words_loaded      - load status
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  cpu_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    // Largest legal word count; compared in 17 bits so a 16-bit N can exceed it.
    localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           buf_q, buf_d;
    // Doubles as word_idx and words_loaded: both clear together and step in WRITE.
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  cpu_enable_q, cpu_enable_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic [15:0]           len_full;
    logic                  last_word;

    assign in_ready  = reset && (state_q == S_LEN_HI || state_q == S_LEN_LO || state_q == S_DATA);
    assign accept    = in_valid && in_ready;
    assign len_full  = {len_hi_q, in_data};
    assign last_word = (17'(cnt_q) + 17'd1) == {1'b0, len_q};

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_LEN_HI;
            len_hi_q     <= '0;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            buf_q        <= '0;
            cnt_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            cpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_enable_q <= cpu_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN_HI: if (accept) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0)              state_d = S_DONE;
                    else if ({1'b0, len_full} > CAP)    state_d = S_ERROR;
                    else                                state_d = S_DATA;
                end
            end
            S_DATA:   if (accept && byte_cnt_q == 2'd3) state_d = S_WRITE;
            S_WRITE:  state_d = last_word ? S_DONE : S_DATA;
            S_DONE,
            S_ERROR:  if (reload) state_d = S_LEN_HI;
            default:  state_d = S_LEN_HI;
        endcase
    end

    // Output / datapath next values (registered above)
    always_comb begin
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_LEN_HI: if (accept) len_hi_d = in_data;
            S_LEN_LO: begin
                if (accept) begin
                    len_d      = len_full;
                    cnt_d      = '0;
                    byte_cnt_d = 2'd0;
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Big-endian: earliest byte ends up in [31:24] after four shifts.
                    buf_d      = {buf_q[23:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            S_WRITE:  cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            S_DONE,
            S_ERROR:  if (reload) cnt_d = '0;
            default:  ;
        endcase

        // Address/data are captured on the edge entering WRITE so they line up with mem_we.
        if (state_q == S_DATA && state_d == S_WRITE) begin
            mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
            mem_wdata_d = buf_d;
        end

        mem_we_d     = (state_d == S_WRITE);
        cpu_reset_d  = (state_d != S_DONE);
        cpu_enable_d = (state_d == S_DONE);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
        busy_d       = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                       (state_d == S_DATA)   || (state_d == S_WRITE);
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign cpu_enable   = cpu_enable_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          reload;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          cpu_enable;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock        (clk),
        .reset        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .reload       (reload),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .cpu_enable   (cpu_enable),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Scoreboard entries: {addr, data} of each write the model says must happen, in order.
    logic [AW+31:0] exp_q[$];
    logic [31:0]    words[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out, expected event (t=%0t)", name, $time);
    endtask

    // ---------------- monitor ----------------
    logic prev_we = 1'b0;
    logic prev_en = 1'b0;
    int   last_evt = 0;   // cycle in which the most recent accept/write takes effect

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (mem_we) begin
            chk("we_single_cycle", prev_we, 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e[AW+31:32]);
                chk("wr_data", mem_wdata, e[31:0]);
            end
            last_evt = cyc + 1;
        end
        if (in_valid && in_ready) last_evt = cyc + 1;
        if (cpu_enable && !prev_en) chk("enable_rise_cycle", cyc, last_evt);
        prev_we = mem_we;
        prev_en = cpu_enable;
    end

    // ---------------- driver / model ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) timeout_fail("in_ready_wait");
        @(posedge clk);
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 3));
    endfunction

    // Streams a frame of length n using words[]; pushes expected writes for legal lengths.
    task automatic send_frame(input int n, input int mode, input int reload_at);
        logic [15:0] len;
        logic [31:0] w;
        len = 16'(n);
        send_byte(len[15:8], pick_gap(mode));
        send_byte(len[7:0],  pick_gap(mode));
        if (n != 0 && n <= (1 << AW)) begin
            for (int i = 0; i < n; i++) begin
                w = words[i];
                for (int b = 0; b < 4; b++) begin
                    if (i == reload_at && b == 1) reload = 1'b1;
                    send_byte(w[31-8*b -: 8], pick_gap(mode));
                    reload = 1'b0;
                end
                exp_q.push_back({AW'(i), w});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input logic exp_done, input int exp_wl);
        int w;
        w = 0;
        while (!(done || error) && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) timeout_fail("end_of_load");
        chk("done", done, exp_done);
        chk("error", error, !exp_done);
        chk("words_loaded", words_loaded, exp_wl);
        chk("cpu_enable", cpu_enable, exp_done);
        chk("cpu_reset", cpu_reset, !exp_done);
        chk("busy_end", busy, 0);
        chk("in_ready_end", in_ready, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_wl", words_loaded, 0);
        chk("reload_done", done, 0);
        chk("reload_error", error, 0);
        chk("reload_busy", busy, 1);
        chk("reload_en", cpu_enable, 0);
        chk("reload_cpu_rst", cpu_reset, 1);
        chk("reload_ready", in_ready, 1);
    endtask

    task automatic check_reset_vals();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_cpu_enable", cpu_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_wl", words_loaded, 0);
        chk("rst_in_ready", in_ready, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_busy", busy, 1);
    endtask

    task automatic random_words(input int n);
        words = {};
        for (int i = 0; i < n; i++) words.push_back($urandom());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        release_reset();

        // N=3 program
        words = {32'h20080005, 32'h20090007, 32'h01095020};
        send_frame(3, 0, -1);
        wait_end(1'b1, 3);

        // N=0
        do_reload();
        send_frame(0, 0, -1);
        wait_end(1'b1, 0);

        // Oversize length, then a single word after reload
        do_reload();
        send_frame(16'h0101, 0, -1);
        wait_end(1'b0, 0);
        do_reload();
        words = {32'hDEADBEEF};
        send_frame(1, 0, -1);
        wait_end(1'b1, 1);

        // Throttled source, in_valid toggling
        do_reload();
        random_words(2);
        send_frame(2, 1, -1);
        wait_end(1'b1, 2);

        // Reset in the middle of word 1
        do_reload();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        release_reset();
        words = {32'h11223344};
        send_frame(1, 0, -1);
        wait_end(1'b1, 1);

        // Full capacity with an ignored reload mid-DATA
        do_reload();
        random_words(1 << AW);
        send_frame(1 << AW, 0, 100);
        wait_end(1'b1, 1 << AW);

        // Largest illegal length
        do_reload();
        send_frame(16'hFFFF, 2, -1);
        wait_end(1'b0, 0);

        // Random frames with random gaps
        for (int f = 0; f < 4; f++) begin
            do_reload();
            n = int'($urandom_range(1, 8));
            random_words(n);
            send_frame(n, 2, -1);
            wait_end(1'b1, n);
        end

        repeat (3) @(negedge clk);
        chk("final_scoreboard", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
